// File: rtl/proj_readout_if.sv
// proj_readout_if: command, RAM read port and stream bundle
// for the projection readout engine.
interface proj_readout_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
);
    logic              iCmdValid;
    logic              oCmdReady;
    logic              iCmdSel;
    logic [ADDR_W-1:0] iCmdBase;
    logic [ADDR_W-1:0] iCmdLen;
    logic              oRdEn;
    logic              oRdSel;
    logic [ADDR_W-1:0] oRdAddr;
    logic [DATA_W-1:0] iRdData;
    logic [DATA_W-1:0] oData;
    logic              oDataValid;
    logic              iDataReady;
    logic              oDone;
    logic              oErr;
    logic [DATA_W-1:0] oPeakVal;
    logic [ADDR_W-1:0] oPeakIdx;
    logic              oBusy;

    modport slave (
        input  iCmdValid, iCmdSel, iCmdBase, iCmdLen,
        input  iRdData, iDataReady,
        output oCmdReady, oRdEn, oRdSel, oRdAddr,
        output oData, oDataValid, oDone, oErr,
        output oPeakVal, oPeakIdx, oBusy
    );

    modport master (
        output iCmdValid, iCmdSel, iCmdBase, iCmdLen,
        output iRdData, iDataReady,
        input  oCmdReady, oRdEn, oRdSel, oRdAddr,
        input  oData, oDataValid, oDone, oErr,
        input  oPeakVal, oPeakIdx, oBusy
    );
endinterface

// File: rtl/proj_readout.sv
// proj_readout: burst reader for the row/column projection banks,
// streams words with backpressure and reports the burst peak.
module proj_readout #(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 10,
    parameter int ROW_DEPTH = 480,
    parameter int COL_DEPTH = 640
) (
    input  logic          iCLK,
    input  logic          iRST,
    proj_readout_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic              sel;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] issueCnt;
    logic [ADDR_W-1:0] xferCnt;
    logic              rdRet;
    logic [DATA_W-1:0] mem [2];
    logic              wrPtr;
    logic              rdPtr;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] runVal;
    logic [ADDR_W-1:0] runIdx;
    logic              cmdReady;
    logic              done;
    logic              err;
    logic              busy;
    logic [DATA_W-1:0] peakVal;
    logic [ADDR_W-1:0] peakIdx;

    logic              pop;
    logic              issue;
    logic              upd;
    logic [2:0]        occ;
    logic [DATA_W-1:0] nextVal;
    logic [ADDR_W-1:0] nextIdx;
    logic [ADDR_W:0]   depth;
    logic [ADDR_W:0]   span;
    logic              tooLong;

    assign pop = (cnt != 2'd0) && bus.iDataReady;
    // a word popped this cycle frees its slot for the read issued now
    assign occ = {1'b0, cnt} + {2'b0, rdRet} - {2'b0, pop};
    assign issue = (state == READ) && (occ < 3'd2);

    assign upd     = pop && (mem[rdPtr] > runVal);
    assign nextVal = upd ? mem[rdPtr] : runVal;
    assign nextIdx = upd ? base + xferCnt : runIdx;

    assign depth = bus.iCmdSel ? (ADDR_W+1)'(COL_DEPTH)
                               : (ADDR_W+1)'(ROW_DEPTH);
    assign span    = {1'b0, bus.iCmdBase} + {1'b0, bus.iCmdLen};
    assign tooLong = span > depth;

    assign bus.oCmdReady  = cmdReady;
    assign bus.oRdEn      = issue;
    assign bus.oRdSel     = sel;
    assign bus.oRdAddr    = base + issueCnt;
    assign bus.oData      = mem[rdPtr];
    assign bus.oDataValid = (cnt != 2'd0);
    assign bus.oDone      = done;
    assign bus.oErr       = err;
    assign bus.oPeakVal   = peakVal;
    assign bus.oPeakIdx   = peakIdx;
    assign bus.oBusy      = busy;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= IDLE;
            sel      <= 1'b0;
            base     <= '0;
            len      <= '0;
            issueCnt <= '0;
            xferCnt  <= '0;
            rdRet    <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            cnt      <= 2'd0;
            runVal   <= '0;
            runIdx   <= '0;
            cmdReady <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            peakVal  <= '0;
            peakIdx  <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdRet <= issue;
            cnt   <= cnt + {1'b0, rdRet} - {1'b0, pop};
            if (rdRet) begin
                mem[wrPtr] <= bus.iRdData;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr   <= ~rdPtr;
                xferCnt <= xferCnt + ADDR_W'(1);
                runVal  <= nextVal;
                runIdx  <= nextIdx;
            end
            unique case (state)
                IDLE: begin
                    if (bus.iCmdValid) begin
                        if (tooLong) begin
                            err <= 1'b1;
                        end else if (bus.iCmdLen == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cmdReady <= 1'b0;
                            peakVal  <= '0;
                            peakIdx  <= bus.iCmdBase;
                        end else begin
                            state    <= READ;
                            sel      <= bus.iCmdSel;
                            base     <= bus.iCmdBase;
                            len      <= bus.iCmdLen;
                            issueCnt <= '0;
                            xferCnt  <= '0;
                            runVal   <= '0;
                            runIdx   <= bus.iCmdBase;
                            busy     <= 1'b1;
                            cmdReady <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        issueCnt <= issueCnt + ADDR_W'(1);
                        if (issueCnt + ADDR_W'(1) == len)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (xferCnt + ADDR_W'(1) == len)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        peakVal <= nextVal;
                        peakIdx <= nextIdx;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cmdReady <= 1'b1;
                end
            endcase
        end
    end
endmodule
